// File: rtl/tawas_thread_sched.sv
// tawas_thread_sched -- barrel-thread scheduler for the Tawas multi-threaded core.
//
// Issues at most one hardware thread per cycle and carries it through a DEPTH-stage
// pipeline (load .. store). A thread that is still in stages 0..DEPTH-2 may not be
// issued again. A thread in the store stage may be issued again, because its
// writeback completes before its next load.
//
// Optional feature macro: TAWAS_SCHED_STATS_EN
//   When defined, the issue and bubble counters are built.
//   When undefined, stat_issue and stat_idle are tied to zero.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   thread_mask[THREADS]        1 = thread enabled
//   rcn_stall[THREADS]          1 = thread blocked on an outstanding RCN load
//   halt                        issue nothing; the pipeline drains
//   thread_load_en/_load        stage 0 valid / thread id
//   thread_decode_en/_decode    stage 1 valid / thread id
//   thread_store_en/_store      stage DEPTH-1 valid / thread id
//   busy[THREADS]               thread present in any stage
//   stat_issue, stat_idle       issued-slot and bubble-slot counters

// Per-thread lane: decides whether this thread is in flight (hazard) or busy,
// and whether it is eligible for issue.
module tawas_thread_sched_lane #(
    parameter int TW    = 5,
    parameter int DEPTH = 3,
    parameter int TID   = 0
) (
    input  logic [DEPTH-1:0]         vld_pipe,
    input  logic [DEPTH-1:0][TW-1:0] id_pipe,
    input  logic                     thread_mask,
    input  logic                     rcn_stall,
    input  logic                     halt,
    output logic                     elig,
    output logic                     busy
);
    localparam logic [TW-1:0] ID = TW'(TID);

    logic inflight;

    always_comb begin
        inflight = 1'b0;
        busy     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_pipe[k] && (id_pipe[k] == ID)) begin
                busy = 1'b1;
                // The store stage does not block re-issue.
                if (k < DEPTH - 1) inflight = 1'b1;
            end
        end
    end

    assign elig = thread_mask & ~rcn_stall & ~inflight & ~halt;
endmodule

module tawas_thread_sched #(
    parameter int THREADS   = 32,
    parameter int TW        = 5,
    parameter int DEPTH     = 3,
    parameter int SKIP_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [THREADS-1:0] thread_mask,
    input  logic [THREADS-1:0] rcn_stall,
    input  logic               halt,
    output logic               thread_load_en,
    output logic [TW-1:0]      thread_load,
    output logic               thread_decode_en,
    output logic [TW-1:0]      thread_decode,
    output logic               thread_store_en,
    output logic [TW-1:0]      thread_store,
    output logic [THREADS-1:0] busy,
    output logic [31:0]        stat_issue,
    output logic [31:0]        stat_idle
);
    // Candidate arithmetic uses one extra bit so that ptr+i (i up to THREADS)
    // can wrap at a non-power-of-2 thread count by a single subtraction.
    localparam int XW = TW + 1;

    logic [DEPTH-1:0]         vld_pipe;
    logic [DEPTH-1:0][TW-1:0] id_pipe;
    logic [TW-1:0]            ptr;
    logic [THREADS-1:0]       elig;
    logic [2**XW-1:0]         elig_x;
    logic [TW-1:0]            slot;
    logic                     pick_vld;
    logic [TW-1:0]            pick_id;

    for (genvar t = 0; t < THREADS; t++) begin : g_lane
        tawas_thread_sched_lane #(
            .TW    (TW),
            .DEPTH (DEPTH),
            .TID   (t)
        ) u_lane (
            .vld_pipe    (vld_pipe),
            .id_pipe     (id_pipe),
            .thread_mask (thread_mask[t]),
            .rcn_stall   (rcn_stall[t]),
            .halt        (halt),
            .elig        (elig[t]),
            .busy        (busy[t])
        );
    end

    // The zero-extended copy lets the wider candidate index address it directly.
    // Unused ids are never eligible.
    assign elig_x = {{(2**XW - THREADS){1'b0}}, elig};

    assign slot = (ptr == TW'(THREADS - 1)) ? '0 : ptr + 1'b1;

    always_comb begin
        logic [XW-1:0] cand;
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        if (SKIP_MODE != 0) begin
            // Round-robin: the first eligible thread after ptr, wrapping.
            for (int i = 1; i <= THREADS; i++) begin
                cand = {1'b0, ptr} + XW'(i);
                if (cand >= XW'(THREADS)) cand = cand - XW'(THREADS);
                if (!pick_vld && elig_x[cand]) begin
                    pick_vld = 1'b1;
                    pick_id  = cand[TW-1:0];
                end
            end
        end else begin
            // Fixed slot: an ineligible slot becomes a bubble.
            pick_vld = elig_x[{1'b0, slot}];
            pick_id  = slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            ptr      <= TW'(THREADS - 1);
        end else begin
            vld_pipe <= {vld_pipe[DEPTH-2:0], pick_vld};
            id_pipe  <= {id_pipe[DEPTH-2:0], pick_id};
            if (SKIP_MODE != 0) begin
                if (pick_vld) ptr <= pick_id;
            end else if (!halt) begin
                ptr <= slot;
            end
        end
    end

    assign thread_load_en   = vld_pipe[0];
    assign thread_load      = id_pipe[0];
    assign thread_decode_en = vld_pipe[1];
    assign thread_decode    = id_pipe[1];
    assign thread_store_en  = vld_pipe[DEPTH-1];
    assign thread_store     = id_pipe[DEPTH-1];

`ifdef TAWAS_SCHED_STATS_EN
    logic [31:0] issue_cnt;
    logic [31:0] idle_cnt;

    // Every cycle out of reset counts exactly one slot: an issue or a bubble.
    // Halt cycles count as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            idle_cnt  <= '0;
        end else if (pick_vld) begin
            issue_cnt <= issue_cnt + 32'd1;
        end else begin
            idle_cnt  <= idle_cnt + 32'd1;
        end
    end

    assign stat_issue = issue_cnt;
    assign stat_idle  = idle_cnt;
`else
    assign stat_issue = 32'h0;
    assign stat_idle  = 32'h0;
`endif
endmodule

// File: tb/tb_tawas_thread_sched.sv
// Scoreboard bench for tawas_thread_sched. Two instances share the stimulus:
//   A: THREADS=32 TW=5 DEPTH=3 SKIP_MODE=1 (defaults)
//   B: THREADS=7  TW=3 DEPTH=4 SKIP_MODE=0
// The driver advances a behavioural model on each negedge and queues the outputs
// expected after the next posedge. The monitor pops and compares 1 time unit
// after that posedge.
module tb_tawas_thread_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mask;
    logic [31:0] stall;
    logic        halt;

    logic        a_le, a_de, a_se;
    logic [4:0]  a_l, a_d, a_s;
    logic [31:0] a_busy, a_si, a_sd;
    logic        b_le, b_de, b_se;
    logic [2:0]  b_l, b_d, b_s;
    logic [6:0]  b_busy;
    logic [31:0] b_si, b_sd;

    always #5 clk = ~clk;

    tawas_thread_sched u_a (
        .clk(clk), .rst(rst), .thread_mask(mask), .rcn_stall(stall), .halt(halt),
        .thread_load_en(a_le), .thread_load(a_l), .thread_decode_en(a_de),
        .thread_decode(a_d), .thread_store_en(a_se), .thread_store(a_s),
        .busy(a_busy), .stat_issue(a_si), .stat_idle(a_sd)
    );

    tawas_thread_sched #(.THREADS(7), .TW(3), .DEPTH(4), .SKIP_MODE(0)) u_b (
        .clk(clk), .rst(rst), .thread_mask(mask[6:0]), .rcn_stall(stall[6:0]), .halt(halt),
        .thread_load_en(b_le), .thread_load(b_l), .thread_decode_en(b_de),
        .thread_decode(b_d), .thread_store_en(b_se), .thread_store(b_s),
        .busy(b_busy), .stat_issue(b_si), .stat_idle(b_sd)
    );

    typedef struct {
        bit          le, de, se, rz;
        int          l, d, s;
        logic [31:0] busy, si, sd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   running = 1'b0;
    int   cyc = 0;

    // Model state: issue history (most recent first, -1 = bubble), pointer, counters.
    int          nt[2] = '{32, 7};
    int          nd[2] = '{3, 4};
    int          nm[2] = '{1, 0};
    int          m_ptr[2];
    int          m_hist[2][4];
    logic [31:0] m_si[2];
    logic [31:0] m_sd[2];

    function automatic bit eligible(int m, int t);
        if (!mask[t] || stall[t] || halt) return 1'b0;
        for (int k = 0; k < nd[m] - 1; k++)
            if (m_hist[m][k] == t) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input int m, output exp_t e);
        int pick;
        pick = -1;
        if (rst) begin
            m_ptr[m] = nt[m] - 1;
            for (int k = 0; k < 4; k++) m_hist[m][k] = -1;
            m_si[m] = 0;
            m_sd[m] = 0;
        end else begin
            if (nm[m] == 1) begin
                for (int i = 1; i <= nt[m]; i++) begin
                    int t;
                    t = (m_ptr[m] + i) % nt[m];
                    if (pick < 0 && eligible(m, t)) pick = t;
                end
                if (pick >= 0) m_ptr[m] = pick;
            end else begin
                int s;
                s = (m_ptr[m] + 1) % nt[m];
                if (eligible(m, s)) pick = s;
                if (!halt) m_ptr[m] = s;
            end
            for (int k = 3; k > 0; k--) m_hist[m][k] = m_hist[m][k-1];
            m_hist[m][0] = pick;
            if (pick >= 0) m_si[m] = m_si[m] + 1;
            else           m_sd[m] = m_sd[m] + 1;
        end
        e.rz = rst;
        e.le = m_hist[m][0] >= 0;        e.l = m_hist[m][0];
        e.de = m_hist[m][1] >= 0;        e.d = m_hist[m][1];
        e.se = m_hist[m][nd[m]-1] >= 0;  e.s = m_hist[m][nd[m]-1];
        e.busy = '0;
        for (int k = 0; k < nd[m]; k++)
            if (m_hist[m][k] >= 0) e.busy[m_hist[m][k]] = 1'b1;
`ifdef TAWAS_SCHED_STATS_EN
        e.si = m_si[m];
        e.sd = m_sd[m];
`else
        e.si = 32'h0;
        e.sd = 32'h0;
`endif
    endtask

    task automatic check(input string nm, input exp_t e, input bit le, input int l,
                         input bit de, input int d, input bit se, input int s,
                         input logic [31:0] bz, input logic [31:0] si, input logic [31:0] sd);
        bit bad;
        bad = (le !== e.le) || (de !== e.de) || (se !== e.se) || (bz !== e.busy) ||
              (si !== e.si) || (sd !== e.sd);
        if (e.le && l != e.l) bad = 1'b1;
        if (e.de && d != e.d) bad = 1'b1;
        if (e.se && s != e.s) bad = 1'b1;
        if (e.rz && (l != 0 || d != 0 || s != 0)) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got le=%0b/%0d de=%0b/%0d se=%0b/%0d busy=%h st=%0d/%0d exp le=%0b/%0d de=%0b/%0d se=%0b/%0d busy=%h st=%0d/%0d",
                     nm, cyc, le, l, de, d, se, s, bz, si, sd,
                     e.le, e.l, e.de, e.d, e.se, e.s, e.busy, e.si, e.sd);
        end
    endtask

    // Monitor: one expected entry per instance per clock once stimulus is running.
    always @(posedge clk) begin
        #1;
        if (running) begin
            exp_t e;
            if (qa.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL inst_a cyc=%0d got no expected entry, required one", cyc);
            end else begin
                e = qa.pop_front();
                check("inst_a", e, a_le, int'(a_l), a_de, int'(a_d), a_se, int'(a_s),
                      a_busy, a_si, a_sd);
            end
            if (qb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL inst_b cyc=%0d got no expected entry, required one", cyc);
            end else begin
                e = qb.pop_front();
                check("inst_b", e, b_le, int'(b_l), b_de, int'(b_d), b_se, int'(b_s),
                      {25'h0, b_busy}, b_si, b_sd);
            end
            cyc++;
        end
    end

    task automatic cycle();
        exp_t ea, eb;
        model_step(0, ea);
        model_step(1, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mask = '0; stall = '0; halt = 1'b0;
        @(negedge clk);
        running = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        // Full mask round robin.
        mask = 32'hFFFF_FFFF;
        repeat (70) cycle();
        // Sparse mask exposes the in-flight hazard.
        mask = 32'h0000_0005;
        repeat (30) cycle();
        // Thread 0 disabled: a periodic bubble in fixed-slot mode.
        mask = 32'hFFFF_FFFE;
        repeat (40) cycle();
        // Thread 3 stalled, then released.
        mask = 32'hFFFF_FFFF;
        stall = 32'h8;
        repeat (40) cycle();
        stall = '0;
        repeat (40) cycle();
        // Halt and drain, then resume.
        halt = 1'b1;
        repeat (6) cycle();
        halt = 1'b0;
        repeat (10) cycle();
        // Reset mid-run.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (20) cycle();
        // Randomised phases.
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 4))
                0: mask = 32'hFFFF_FFFF;
                1: mask = 32'h0000_0005;
                2: mask = 32'hFFFF_FFFE;
                3: mask = $urandom;
                default: mask = $urandom & $urandom;
            endcase
            for (int c = 0; c < 50; c++) begin
                stall = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
                halt  = ($urandom_range(0, 15) == 0);
                rst   = ($urandom_range(0, 199) == 0);
                cycle();
            end
        end
        rst = 1'b0; halt = 1'b0; stall = '0;
        running = 1'b0;
        if (qa.size() != 0 || qb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain got %0d/%0d leftover entries, required 0/0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
